ins_fetch: RTL and testbench
============================

INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, PC value loaded on reset; SHALL be word-aligned.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_insFetch  input  1  reset, asynchronous, active-low.
REQ-004 imem_req  output  1  instruction memory read request.
REQ-005 imem_addr  output  32  byte address of requested word (= pc).
REQ-006 imem_ready  input  1  memory returns imem_rdata this cycle.
REQ-007 imem_rdata  input  32  instruction word from memory.
REQ-008 instruction  output  32  registered instruction word to the decoder.
REQ-009 ins_valid  output  1  instruction holds a valid, not-yet-retired word.
REQ-010 ins_ready  input  1  datapath has completed the current instruction.
REQ-011 npc_sel  input  1  decoded beq.
REQ-012 alu_zero  input  1  ALU equality result for beq.
REQ-013 isJump  input  1  decoded j.
REQ-014 imm16  input  16  branch offset field.
REQ-015 imm26  input  26  jump target field.
REQ-016 pc  output  32  address of the current instruction.
REQ-017 ins_count  output  32  number of retired instructions.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, ISSUE; reset state IDLE.
REQ-019 IDLE SHALL go to FETCH on the next clock edge unconditionally.
REQ-020 imem_req SHALL be 1 exactly when state is FETCH (combinational from state); imem_addr SHALL equal pc at all times.
REQ-021 In FETCH with imem_ready=1: instruction <= imem_rdata, state -> ISSUE; with imem_ready=0: remain in FETCH, request held, pc stable.
REQ-022 imem_ready while not in FETCH SHALL be ignored; instruction SHALL not change.
REQ-023 ins_valid SHALL be 1 exactly when state is ISSUE.
REQ-024 In ISSUE with ins_ready=1: pc <= npc, ins_count <= ins_count+1, state -> FETCH; with ins_ready=0: all state held.
REQ-025 npc SHALL be computed from inputs sampled in the retiring cycle: pc4 = pc+4.
REQ-026 isJump=1: npc = {pc4[31:28], imm26, 2'b00}; jump SHALL take priority over branch when both asserted.
REQ-027 else npc_sel=1 and alu_zero=1: npc = pc4 + (sign-extended imm16 << 2), modulo 2^32.
REQ-028 otherwise npc = pc4.
REQ-029 pc arithmetic SHALL wrap modulo 2^32 (0xFFFF_FFFC + 4 = 0); ins_count SHALL wrap from 0xFFFF_FFFF to 0.
REQ-030 Minimum fetch-to-fetch period SHALL be 2 cycles (FETCH with immediate ready, ISSUE with immediate ins_ready).
REQ-031 pc[1:0] SHALL always be 00.

Reset
REQ-032 While rst_insFetch=0: state=IDLE, pc=RESET_PC, instruction=0, ins_count=0, imem_req=0, ins_valid=0, asynchronously.
REQ-033 Reset asserted mid-FETCH or mid-ISSUE SHALL abandon the access; a late imem_ready after release SHALL be ignored until FETCH is re-entered.

Structure
REQ-034 Shared package SHALL hold the FSM state encoding, the default RESET_PC and the opcode constants (beq 000100, j 000010) reused by the decoder.
REQ-035 Next-PC computation SHALL be a separate combinational sub-module npc_calc (inputs pc, npc_sel, alu_zero, isJump, imm16, imm26; output npc).

Verification
REQ-036 Reset release, imem_ready tied 1, ins_ready tied 1, no branch/jump -> imem_addr 0x3000, 0x3004, 0x3008 every 2 cycles; ins_count increments each retire.
REQ-037 imem_ready held 0 for 5 cycles in FETCH -> imem_req stays 1, imem_addr constant, ins_valid 0; rdata captured on 6th cycle.
REQ-038 pc=0x3010, npc_sel=1, alu_zero=1, imm16=0xFFFF -> next pc 0x3010; alu_zero=0 -> 0x3014.
REQ-039 pc=0x3000, isJump=1, imm26=0x0000C10, npc_sel=1, alu_zero=1 -> next pc 0x0000_3040 (jump wins).
REQ-040 RESET_PC=0xFFFF_FFFC, sequential retire -> next pc 0x0000_0000.
REQ-041 Reset pulsed during ISSUE with ins_ready=0 -> pc=RESET_PC, ins_valid=0, ins_count=0 immediately; stray imem_ready in IDLE ignored.

Source files
------------

// File: rtl/ins_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, reset PC
// default and the opcode constants also consumed by the decoder.
package ins_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetchState_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

endpackage

// File: rtl/ins_fetch_npc_calc.sv
// Next-PC selection for the fetch stage: jump target, taken beq, or pc+4.
// Purely combinational; the caller decides when the result is committed.
module npc_calc
  import ins_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        npc_sel,
  input  logic        alu_zero,
  input  logic        isJump,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  output logic [31:0] npc
);

  logic [31:0] pc4_s;
  logic [31:0] branchOff_s;

  // Jump wins over a taken branch when the decoder flags both.
  always_comb begin
    pc4_s       = pc + 32'd4;
    branchOff_s = {{14{imm16[15]}}, imm16, 2'b00};
    if (isJump) begin
      npc = {pc4_s[31:28], imm26, 2'b00};
    end else if (npc_sel && alu_zero) begin
      npc = pc4_s + branchOff_s;
    end else begin
      npc = pc4_s;
    end
  end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: requests one word per instruction, holds it for the
// datapath until retired, then advances pc through npc_calc.
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_insFetch,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        npc_sel,
  input  logic        alu_zero,
  input  logic        isJump,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  output logic [31:0] pc,
  output logic [31:0] ins_count
);

  fetchState_t state_r;
  logic [31:0] pc_r;
  logic [31:0] instruction_r;
  logic [31:0] insCount_r;
  logic [31:0] npc_s;

  npc_calc u_npcCalc (
    .pc       (pc_r),
    .npc_sel  (npc_sel),
    .alu_zero (alu_zero),
    .isJump   (isJump),
    .imm16    (imm16),
    .imm26    (imm26),
    .npc      (npc_s)
  );

  // Fetch/issue sequencing; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_insFetch) begin
    if (!rst_insFetch) begin
      state_r       <= IDLE;
      pc_r          <= {RESET_PC[31:2], 2'b00};
      instruction_r <= 32'd0;
      insCount_r    <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= FETCH;
        end
        FETCH: begin
          if (imem_ready) begin
            instruction_r <= imem_rdata;
            state_r       <= ISSUE;
          end
        end
        ISSUE: begin
          if (ins_ready) begin
            pc_r       <= npc_s;
            insCount_r <= insCount_r + 32'd1;
            state_r    <= FETCH;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Handshake strobes are pure decodes of the state register.
  always_comb begin
    imem_req    = (state_r == FETCH);
    ins_valid   = (state_r == ISSUE);
    imem_addr   = pc_r;
    pc          = pc_r;
    instruction = instruction_r;
    ins_count   = insCount_r;
  end

endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: directed scenarios plus a randomized
// instruction stream checked against a transaction-level next-pc model.
module tb_ins_fetch;

  logic        clk;
  logic        rst_insFetch;
  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction, instruction2;
  logic        ins_valid, ins_valid2;
  logic        ins_ready;
  logic        npc_sel, alu_zero, isJump;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] pc, pc2;
  logic [31:0] ins_count, ins_count2;

  int checks = 0;
  int errors = 0;

  logic [31:0] expPc, expIns, expCnt;

  ins_fetch dut (
    .clk(clk), .rst_insFetch(rst_insFetch), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instruction(instruction),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .npc_sel(npc_sel), .alu_zero(alu_zero),
    .isJump(isJump), .imm16(imm16), .imm26(imm26), .pc(pc), .ins_count(ins_count)
  );

  ins_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_insFetch(rst_insFetch), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instruction(instruction2),
    .ins_valid(ins_valid2), .ins_ready(ins_ready), .npc_sel(npc_sel), .alu_zero(alu_zero),
    .isJump(isJump), .imm16(imm16), .imm26(imm26), .pc(pc2), .ins_count(ins_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural next-pc rule, written as plain arithmetic.
  function automatic logic [31:0] refNpc(input logic [31:0] p, input logic sel, input logic zero,
                                         input logic jump, input logic [15:0] i16, input logic [25:0] i26);
    logic [31:0] p4;
    int off;
    p4  = p + 32'd4;
    off = $signed(i16);
    if (jump) return (p4 & 32'hF000_0000) + ({6'd0, i26} * 32'd4);
    else if (sel && zero) return p4 + 32'(off * 4);
    else return p4;
  endfunction

  task automatic clearBranch();
    npc_sel = 1'b0; alu_zero = 1'b0; isJump = 1'b0; imm16 = 16'd0; imm26 = 26'd0;
  endtask

  // Reset then release; returns at the first negedge with the DUT in FETCH.
  task automatic doReset();
    @(negedge clk);
    rst_insFetch = 1'b0; imem_ready = 1'b0; ins_ready = 1'b0; clearBranch();
    @(negedge clk);
    rst_insFetch = 1'b1;
    @(negedge clk);
    expPc = 32'h0000_3000; expCnt = 32'd0; expIns = 32'd0;
  endtask

  // From FETCH: fetch immediately, retire with given branch inputs, back in FETCH.
  task automatic stepInstr(input logic sel, input logic zero, input logic jump,
                           input logic [15:0] i16, input logic [25:0] i26);
    imem_ready = 1'b1; imem_rdata = $urandom;
    @(negedge clk);
    imem_ready = 1'b0; ins_ready = 1'b1;
    npc_sel = sel; alu_zero = zero; isJump = jump; imm16 = i16; imm26 = i26;
    @(negedge clk);
    ins_ready = 1'b0; clearBranch();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_insFetch = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; ins_ready = 1'b1; clearBranch();
    @(negedge clk);
    @(negedge clk);
    checks++; if (pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0000_3000); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ins_valid); end
    checks++; if (ins_count !== 32'd0) begin errors++; $display("FAIL reset_count got %h want 0", ins_count); end
    checks++; if (instruction !== 32'd0) begin errors++; $display("FAIL reset_ins got %h want 0", instruction); end
    checks++; if (pc2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc2 got %h want fffffffc", pc2); end
  endtask

  task automatic test_sequential();
    logic [31:0] r;
    @(negedge clk);
    rst_insFetch = 1'b1; imem_ready = 1'b1; ins_ready = 1'b1; clearBranch();
    @(negedge clk);
    expPc = 32'h0000_3000; expCnt = 32'd0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (imem_req !== 1'b1 || ins_valid !== 1'b0) begin errors++; $display("FAIL seq_fetch req %b valid %b want 1 0", imem_req, ins_valid); end
      checks++; if (imem_addr !== expPc) begin errors++; $display("FAIL seq_addr got %h want %h", imem_addr, expPc); end
      r = $urandom; imem_rdata = r;
      @(negedge clk);
      checks++; if (ins_valid !== 1'b1 || instruction !== r) begin errors++; $display("FAIL seq_issue valid %b ins %h want 1 %h", ins_valid, instruction, r); end
      checks++; if (ins_count !== expCnt) begin errors++; $display("FAIL seq_count got %h want %h", ins_count, expCnt); end
      @(negedge clk);
      expPc = expPc + 32'd4; expCnt = expCnt + 32'd1;
    end
    expIns = r;
    ins_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] r;
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      imem_rdata = $urandom; ins_ready = 1'($urandom);
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || ins_valid !== 1'b0) begin errors++; $display("FAIL stall_state req %b valid %b want 1 0", imem_req, ins_valid); end
      checks++; if (imem_addr !== expPc || instruction !== expIns) begin errors++; $display("FAIL stall_hold addr %h ins %h want %h %h", imem_addr, instruction, expPc, expIns); end
    end
    r = $urandom; imem_rdata = r; imem_ready = 1'b1; ins_ready = 1'b0;
    @(negedge clk);
    imem_ready = 1'b0;
    checks++; if (ins_valid !== 1'b1 || instruction !== r) begin errors++; $display("FAIL stall_capture valid %b ins %h want 1 %h", ins_valid, instruction, r); end
    ins_ready = 1'b1;
    @(negedge clk);
    ins_ready = 1'b0;
    expPc = expPc + 32'd4; expCnt = expCnt + 32'd1; expIns = r;
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic sel, zero, jump;
    logic [15:0] i16;
    logic [25:0] i26;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) begin
        imem_ready = 1'b0; imem_rdata = $urandom; ins_ready = 1'($urandom);
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || ins_valid !== 1'b0 || imem_addr !== expPc || instruction !== expIns) begin
          errors++; $display("FAIL rnd_fetch req %b valid %b addr %h ins %h want 1 0 %h %h", imem_req, ins_valid, imem_addr, instruction, expPc, expIns); end
      end
      r = $urandom; imem_rdata = r; imem_ready = 1'b1; ins_ready = 1'($urandom);
      @(negedge clk);
      expIns = r;
      repeat ($urandom_range(0, 3)) begin
        ins_ready = 1'b0; imem_ready = 1'($urandom); imem_rdata = $urandom;
        npc_sel = 1'($urandom); isJump = 1'($urandom);
        checks++; if (ins_valid !== 1'b1 || imem_req !== 1'b0 || instruction !== expIns || pc !== expPc || ins_count !== expCnt) begin
          errors++; $display("FAIL rnd_issue valid %b req %b ins %h pc %h cnt %h want 1 0 %h %h %h", ins_valid, imem_req, instruction, pc, ins_count, expIns, expPc, expCnt); end
        @(negedge clk);
      end
      checks++; if (ins_valid !== 1'b1 || instruction !== expIns || pc !== expPc || ins_count !== expCnt) begin
        errors++; $display("FAIL rnd_retire valid %b ins %h pc %h cnt %h want 1 %h %h %h", ins_valid, instruction, pc, ins_count, expIns, expPc, expCnt); end
      sel = 1'($urandom); zero = 1'($urandom); jump = ($urandom_range(0, 3) == 0);
      i16 = 16'($urandom); i26 = 26'($urandom);
      npc_sel = sel; alu_zero = zero; isJump = jump; imm16 = i16; imm26 = i26;
      ins_ready = 1'b1; imem_ready = 1'($urandom);
      expPc = refNpc(expPc, sel, zero, jump, i16, i26); expCnt = expCnt + 32'd1;
      @(negedge clk);
      ins_ready = 1'b0; clearBranch();
      checks++; if (pc !== expPc || imem_addr !== expPc || pc[1:0] !== 2'b00 || ins_count !== expCnt) begin
        errors++; $display("FAIL rnd_npc pc %h addr %h cnt %h want %h %h", pc, imem_addr, ins_count, expPc, expCnt); end
    end
  endtask

  task automatic test_branch();
    doReset();
    repeat (4) stepInstr(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
    checks++; if (pc !== 32'h0000_3010) begin errors++; $display("FAIL br_setup got %h want 00003010", pc); end
    stepInstr(1'b1, 1'b1, 1'b0, 16'hFFFF, 26'd0);
    checks++; if (pc !== 32'h0000_3010) begin errors++; $display("FAIL br_taken got %h want 00003010", pc); end
    stepInstr(1'b1, 1'b0, 1'b0, 16'hFFFF, 26'd0);
    checks++; if (pc !== 32'h0000_3014) begin errors++; $display("FAIL br_nottaken got %h want 00003014", pc); end
    checks++; if (ins_count !== 32'd6) begin errors++; $display("FAIL br_count got %0d want 6", ins_count); end
  endtask

  task automatic test_jump();
    doReset();
    stepInstr(1'b1, 1'b1, 1'b1, 16'h0040, 26'h000_0C10);
    checks++; if (pc !== 32'h0000_3040 || imem_addr !== 32'h0000_3040) begin errors++; $display("FAIL jump_wins pc %h addr %h want 00003040", pc, imem_addr); end
  endtask

  task automatic test_wrap();
    doReset();
    checks++; if (imem_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start got %h want fffffffc", imem_addr2); end
    stepInstr(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
    checks++; if (pc2 !== 32'h0000_0000 || ins_count2 !== 32'd1) begin errors++; $display("FAIL wrap_pc pc %h cnt %h want 0 1", pc2, ins_count2); end
  endtask

  task automatic test_reset_midissue();
    logic [31:0] r;
    doReset();
    stepInstr(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
    stepInstr(1'b0, 1'b0, 1'b0, 16'd0, 26'd0);
    imem_ready = 1'b1; imem_rdata = $urandom;
    @(negedge clk);
    imem_ready = 1'b0; ins_ready = 1'b0;
    checks++; if (ins_valid !== 1'b1 || ins_count !== 32'd2) begin errors++; $display("FAIL mid_setup valid %b cnt %h want 1 2", ins_valid, ins_count); end
    #2 rst_insFetch = 1'b0;
    #1;
    checks++; if (pc !== 32'h0000_3000 || ins_valid !== 1'b0 || ins_count !== 32'd0) begin
      errors++; $display("FAIL mid_async pc %h valid %b cnt %h want 00003000 0 0", pc, ins_valid, ins_count); end
    checks++; if (instruction !== 32'd0 || imem_req !== 1'b0) begin errors++; $display("FAIL mid_async2 ins %h req %b want 0 0", instruction, imem_req); end
    @(negedge clk);
    rst_insFetch = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || ins_valid !== 1'b0 || instruction !== 32'd0) begin
      errors++; $display("FAIL mid_stray req %b valid %b ins %h want 1 0 0", imem_req, ins_valid, instruction); end
    r = $urandom; imem_rdata = r;
    @(negedge clk);
    imem_ready = 1'b0;
    checks++; if (ins_valid !== 1'b1 || instruction !== r || pc !== 32'h0000_3000) begin
      errors++; $display("FAIL mid_refetch valid %b ins %h pc %h want 1 %h 00003000", ins_valid, instruction, pc, r); end
  endtask

  initial begin
    rst_insFetch = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0; ins_ready = 1'b0;
    npc_sel = 1'b0; alu_zero = 1'b0; isJump = 1'b0; imm16 = 16'd0; imm26 = 26'd0;
    test_reset();
    test_sequential();
    test_stall();
    test_random();
    test_branch();
    test_jump();
    test_wrap();
    test_reset_midissue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
